// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: RV opcodes, the bubble instruction
// and the writeback-source encoding, plus small opcode classification helpers.
package decode_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC     = 7'b001_0111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b001_1011;
    localparam logic [6:0] OPC_STORE     = 7'b010_0011;
    localparam logic [6:0] OPC_OP        = 7'b011_0011;
    localparam logic [6:0] OPC_LUI       = 7'b011_0111;
    localparam logic [6:0] OPC_OP_32     = 7'b011_1011;
    localparam logic [6:0] OPC_BRANCH    = 7'b110_0011;
    localparam logic [6:0] OPC_JALR      = 7'b110_0111;
    localparam logic [6:0] OPC_JAL       = 7'b110_1111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd3
    } wb_src_e;

    // U and J formats carry no rs1 field
    function automatic logic rs1_used(input logic [6:0] opcode);
        return !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    endfunction

    // Only R, S and B formats read rs2
    function automatic logic rs2_used(input logic [6:0] opcode);
        return opcode inside {OPC_OP, OPC_OP_32, OPC_STORE, OPC_BRANCH};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake plus the registered decode payload.
interface decode_stage_if #(
    parameter int XLEN = 32
) ();

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] instruction_address;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     instruction_to_exe;
    logic [XLEN-1:0] instruction_address_to_exe;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] ex_immediate;
    logic            ex_aluop1_source;
    logic            ex_aluop2_source;
    logic            memory_read_enable;
    logic            memory_write_enable;
    logic [1:0]      wb_reg_write_source;
    logic            reg_write_enable;
    logic            illegal;

    // Environment side: drives fetch data and the EX consume strobe
    modport master (
        output in_valid, instruction, instruction_address, out_ready,
        input  in_ready, out_valid, instruction_to_exe, instruction_address_to_exe,
        input  rs1_addr, rs2_addr, rd_addr, ex_immediate, ex_aluop1_source,
        input  ex_aluop2_source, memory_read_enable, memory_write_enable,
        input  wb_reg_write_source, reg_write_enable, illegal
    );

    // Decode stage side
    modport slave (
        input  in_valid, instruction, instruction_address, out_ready,
        output in_ready, out_valid, instruction_to_exe, instruction_address_to_exe,
        output rs1_addr, rs2_addr, rd_addr, ex_immediate, ex_aluop1_source,
        output ex_aluop2_source, memory_read_enable, memory_write_enable,
        output wb_reg_write_source, reg_write_enable, illegal
    );

endinterface

// File: rtl/imm_gen.sv
// Combinational immediate generator: picks the RV immediate layout from the
// opcode and sign-extends bit 31 to XLEN.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] immediate
);

    logic [31:0] imm32;

    // Assemble the 32-bit immediate; unknown opcodes fall back to I-format
    always_comb begin
        imm32 = {{20{instruction[31]}}, instruction[31:20]};
        case (instruction[6:0])
            OPC_STORE:          imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            OPC_BRANCH:         imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                                         instruction[30:25], instruction[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: imm32 = {instruction[31:12], 12'h000};
            OPC_JAL:            imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                                         instruction[20], instruction[30:21], 1'b0};
            default:            imm32 = {{20{instruction[31]}}, instruction[31:20]};
        endcase
    end

    assign immediate = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32/RV64 decode stage: decodes the fetched word, stalls on a load-use
// hazard against EX, and holds the decoded payload in one pipeline register
// with a valid/ready handshake toward EX.
module decode_stage
    import decode_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [4:0]    ex_rd,
    input  logic          ex_mem_read,
    decode_stage_if.slave bus
);

    logic [31:0]     ins;
    logic [6:0]      opcode;
    logic [4:0]      rs1_field;
    logic [4:0]      rs2_field;
    logic [4:0]      rd_field;
    logic [XLEN-1:0] imm;
    logic            hazard;
    logic            in_ready_int;
    logic            accept;

    logic            dec_op1;
    logic            dec_op2;
    logic            dec_mr;
    logic            dec_mw;
    logic            dec_writes;
    logic            dec_ill;
    logic            dec_rwe;
    logic [4:0]      dec_rs1;
    wb_src_e         dec_wb;

    assign ins       = bus.instruction;
    assign opcode    = ins[6:0];
    assign rs1_field = ins[19:15];
    assign rs2_field = ins[24:20];
    assign rd_field  = ins[11:7];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instruction (ins),
        .immediate   (imm)
    );

    // Load-use hazard: a load in EX writes a register this instruction reads
    always_comb begin
        hazard = 1'b0;
        if (bus.in_valid && ex_mem_read && (ex_rd != 5'd0)) begin
            hazard = (rs1_used(opcode) && (ex_rd == rs1_field)) ||
                     (rs2_used(opcode) && (ex_rd == rs2_field));
        end else begin
            hazard = 1'b0;
        end
    end

    assign in_ready_int = !rst && (!bus.out_valid || bus.out_ready) && !hazard && !flush;
    assign bus.in_ready = in_ready_int;
    assign accept       = bus.in_valid && in_ready_int;

    // Control decode; illegal words keep their fields but never write state
    always_comb begin
        dec_op1    = 1'b0;
        dec_op2    = 1'b1;
        dec_mr     = 1'b0;
        dec_mw     = 1'b0;
        dec_writes = 1'b0;
        dec_ill    = 1'b0;
        dec_rs1    = rs1_field;
        dec_wb     = WB_ALU;
        case (opcode)
            OPC_LOAD:      begin dec_mr = 1'b1; dec_wb = WB_MEM; dec_writes = 1'b1; end
            OPC_OP_IMM:    begin dec_writes = 1'b1; end
            OPC_AUIPC:     begin dec_op1 = 1'b1; dec_writes = 1'b1; end
            OPC_OP_IMM_32: begin dec_writes = 1'b1; dec_ill = (XLEN == 32); end
            OPC_STORE:     begin dec_mw = 1'b1; end
            OPC_OP:        begin dec_op2 = 1'b0; dec_writes = 1'b1; end
            OPC_LUI:       begin dec_rs1 = 5'd0; dec_writes = 1'b1; end
            OPC_OP_32:     begin dec_op2 = 1'b0; dec_writes = 1'b1; dec_ill = (XLEN == 32); end
            OPC_BRANCH:    begin dec_op1 = 1'b1; end
            OPC_JALR:      begin dec_wb = WB_PC4; dec_writes = 1'b1; end
            OPC_JAL:       begin dec_op1 = 1'b1; dec_wb = WB_PC4; dec_writes = 1'b1; end
            default:       begin dec_ill = 1'b1; end
        endcase
        dec_ill = dec_ill || (ins[1:0] != 2'b11);
        dec_rwe = dec_writes && (rd_field != 5'd0) && !dec_ill;
        dec_mr  = dec_mr && !dec_ill;
        dec_mw  = dec_mw && !dec_ill;
    end

    // Pipeline register: reset/flush/drain load a bubble, accept loads, else hold
    always_ff @(posedge clk) begin
        if (rst || flush || (bus.out_ready && !accept)) begin
            bus.out_valid           <= 1'b0;
            bus.instruction_to_exe  <= NOP_INSTR;
            bus.rs1_addr            <= 5'd0;
            bus.rs2_addr            <= 5'd0;
            bus.rd_addr             <= 5'd0;
            bus.ex_immediate        <= '0;
            bus.ex_aluop1_source    <= 1'b0;
            bus.ex_aluop2_source    <= 1'b1;
            bus.memory_read_enable  <= 1'b0;
            bus.memory_write_enable <= 1'b0;
            bus.wb_reg_write_source <= WB_ALU;
            bus.reg_write_enable    <= 1'b0;
            bus.illegal             <= 1'b0;
            // A bubble keeps the PC of the last instruction except on reset
            if (rst) begin
                bus.instruction_address_to_exe <= '0;
            end
        end else if (accept) begin
            bus.out_valid                  <= 1'b1;
            bus.instruction_to_exe         <= ins;
            bus.instruction_address_to_exe <= bus.instruction_address;
            bus.rs1_addr                   <= dec_rs1;
            bus.rs2_addr                   <= rs2_field;
            bus.rd_addr                    <= rd_field;
            bus.ex_immediate               <= imm;
            bus.ex_aluop1_source           <= dec_op1;
            bus.ex_aluop2_source           <= dec_op2;
            bus.memory_read_enable         <= dec_mr;
            bus.memory_write_enable        <= dec_mw;
            bus.wb_reg_write_source        <= dec_wb;
            bus.reg_write_enable           <= dec_rwe;
            bus.illegal                    <= dec_ill;
        end
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath/immediate width; legal values 32 and 64.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  fetch holds a valid instruction.
REQ-006 in_ready  output  1  stage accepts instruction this cycle.
REQ-007 instruction / instruction_address  input  32 / XLEN  fetched word and its PC.
REQ-008 flush  input  1  squash fetched instruction and pipeline register.
REQ-009 ex_rd / ex_mem_read  input  5 / 1  destination and load flag of the instruction currently in EX.
REQ-010 out_valid  output  1  decoded payload valid toward EX.
REQ-011 out_ready  input  1  EX consumes payload this cycle.
REQ-012 Registered payload outputs: instruction_to_exe 32, instruction_address_to_exe XLEN, rs1_addr 5, rs2_addr 5, rd_addr 5, ex_immediate XLEN, ex_aluop1_source 1 (1=PC), ex_aluop2_source 1 (1=imm), memory_read_enable 1, memory_write_enable 1, wb_reg_write_source 2 (0 ALU, 1 mem, 3 PC+4), reg_write_enable 1, illegal 1.

Function
REQ-013 in_ready = (!out_valid | out_ready) & !hazard & !flush.
REQ-014 hazard = in_valid & ex_mem_read & ex_rd!=0 & (ex_rd==rs1 with rs1 used | ex_rd==rs2 with rs2 used); rs1 unused for LUI/AUIPC/JAL, rs2 used only for R, S, B types.
REQ-015 Accept (in_valid & in_ready): payload registered next edge, out_valid<=1; latency exactly 1 cycle.
REQ-016 out_valid & !out_ready & !flush: all payload and out_valid hold unchanged.
REQ-017 out_ready & no accept & !flush: out_valid<=0, payload set to bubble.
REQ-018 Bubble: instruction_to_exe=NOP_INSTR, all addresses 0, immediate 0, aluop1_source 0, aluop2_source 1, memory enables 0, wb source 0, reg_write_enable 0, illegal 0; address field retains previous value.
REQ-019 flush has priority over accept and hold: next edge out_valid<=0, payload=bubble; incoming instruction dropped.
REQ-020 Immediates sign-extended from bit 31 to XLEN: I (OP-IMM, LOAD, JALR, OP-IMM-32), S, B (bit0=0), U (LUI, AUIPC, low 12 zero), J (JAL, bit0=0); other opcodes: I-format.
REQ-021 aluop1_source=1 for BRANCH, AUIPC, JAL; aluop2_source=0 only for OP and OP-32.
REQ-022 LUI forces rs1_addr=0.
REQ-023 reg_write_enable=1 for OP, OP-IMM, LOAD, AUIPC, LUI, JAL, JALR (plus OP-32, OP-IMM-32 when XLEN=64), and only when rd!=0.
REQ-024 wb source: LOAD 1; JAL/JALR 3; else 0.
REQ-025 illegal=1 when instruction[1:0]!=2'b11, opcode unlisted, or OP-32/OP-IMM-32 with XLEN=32; illegal payload has reg_write_enable, memory enables forced 0, out_valid=1.
REQ-026 Hazard and out_ready simultaneous: EX drains, stage emits bubble (out_valid<=0), instruction stays upstream.

Reset
REQ-027 rst at edge: out_valid=0, payload=bubble, instruction_address_to_exe=0, regardless of other inputs including mid-hold.
REQ-028 in_ready=0 while rst asserted.

Structure
REQ-029 Opcode constants, NOP_INSTR default and wb-source encodings in shared package decode_pkg.
REQ-030 Immediate generation in combinational sub-module imm_gen (parameter XLEN).
REQ-031 No latches; single always block for pipeline register.

Verification
REQ-032 addi x1,x2,-1 (0xFFF10093), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, rs1=2, rd=1, reg_write_enable=1.
REQ-033 lw x5 in EX (ex_rd=5, ex_mem_read=1), fetch add x6,x5,x7 -> in_ready=0, out_valid=0 next cycle; ex_mem_read drops -> accepted one cycle later.
REQ-034 out_ready=0 for 3 cycles after accept of sw -> payload unchanged each cycle, memory_write_enable=1, in_ready=0.
REQ-035 flush with in_valid=1 and held payload -> next cycle out_valid=0, instruction_to_exe=0x00000013, reg_write_enable=0.
REQ-036 XLEN=64 addiw (opcode 0011011) -> illegal=0, 64-bit sign-extended imm; XLEN=32 same word -> illegal=1, reg_write_enable=0.
REQ-037 rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, bubble payload.
